pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline-control and hazard unit for the MIPS pipelined CPU, and the successor to the fixed 5-stage controller's stall/forward logic. Unlike that logic, it keeps its own in-flight destination scoreboard, advancing one entry per stage. It handles configurable depth, load latency and source-operand count, plus exception flush, debug single-step and saturating stall/flush counters. It sits beside the decoder, taking decoded ID-stage fields and driving per-stage enable/reset and per-operand forwarding selects.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/fwd_match.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and helpers for the pipeline-control / hazard unit.
// Stage indices, the register-file forward code and the forward-select width.
package pipe_ctrl_pkg;

    localparam int unsigned STG_IF      = 0;
    localparam int unsigned STG_ID      = 1;
    localparam int unsigned STG_EXE     = 2;
    localparam int unsigned FWD_REGFILE = 0;

    // The control event that wins the priority decode in a given cycle.
    typedef enum logic [2:0] {
        EvNone,
        EvReset,
        EvDebug,
        EvExc,
        EvRom,
        EvRam,
        EvLoad,
        EvFlush
    } ctrl_ev_e;

    function automatic int unsigned fw_width(input int unsigned num_stages);
        return (num_stages <= 2) ? 1 : $clog2(num_stages);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder-side bundle of the hazard unit: decoded ID fields and stall/flush requests in,
// per-stage enables/resets, forwarding selects and counters out.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned CNT_W      = 16
) ();
    localparam int unsigned FW = fw_width(NUM_STAGES);

    logic                      debug_en;
    logic                      debug_step;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_wen;
    logic [ADDR_W-1:0]         id_waddr;
    logic                      id_is_load;
    logic                      id_is_store;
    logic                      rom_stall;
    logic                      ram_stall;
    logic                      flush_req;
    logic                      exc_req;
    logic [NUM_STAGES-1:0]     stage_en;
    logic [NUM_STAGES-1:0]     stage_rst;
    logic [NUM_SRC*FW-1:0]     fwd_sel;
    logic                      fwd_m;
    logic                      load_stall;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          flush_cnt;

    modport master (
        output debug_en, debug_step, id_valid, id_src_addr, id_src_used, id_wen, id_waddr,
               id_is_load, id_is_store, rom_stall, ram_stall, flush_req, exc_req,
        input  stage_en, stage_rst, fwd_sel, fwd_m, load_stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  debug_en, debug_step, id_valid, id_src_addr, id_src_used, id_wen, id_waddr,
               id_is_load, id_is_store, rom_stall, ram_stall, flush_req, exc_req,
        output stage_en, stage_rst, fwd_sel, fwd_m, load_stall, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_match.sv
// Priority search of the in-flight scoreboard for one ID source operand.
// Reports the youngest matching stage and whether that producer is not yet forwardable.
module fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FW         = fw_width(NUM_STAGES)
) (
    input  logic                             used,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [NUM_STAGES-1:2]            sb_valid,
    input  logic [NUM_STAGES-1:2]            sb_wen,
    input  logic [NUM_STAGES-1:2]            sb_load,
    input  logic [(NUM_STAGES-2)*ADDR_W-1:0] sb_waddr,
    output logic [FW-1:0]                    sel,
    output logic                             hazard
);

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel    = FW'(FWD_REGFILE);
        hazard = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 2; k--) begin
            if (used && (addr != '0) && sb_valid[k] && sb_wen[k] &&
                (sb_waddr[(k-2)*ADDR_W +: ADDR_W] == addr)) begin
                sel    = FW'(k);
                hazard = sb_load[k] && (k < 2 + int'(LOAD_LAT));
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline control and hazard unit: destination scoreboard, operand forwarding,
// load-use stall, prioritised stall/flush/exception/debug control and saturating counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned EXC_DEPTH  = 3,
    parameter int unsigned DBG_EN     = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned FW       = fw_width(NUM_STAGES);
    localparam int unsigned LAST     = NUM_STAGES - 1;
    localparam int unsigned DATA_SRC = (NUM_SRC > 1) ? 1 : 0;

    logic [NUM_STAGES-1:2]            sb_valid_q, sb_wen_q, sb_load_q;
    logic [(NUM_STAGES-2)*ADDR_W-1:0] sb_waddr_q;
    logic                             step_prev_q;
    logic [CNT_W-1:0]                 stall_cnt_q, flush_cnt_q;

    logic [FW-1:0]         src_sel [NUM_SRC];
    logic [NUM_SRC-1:0]    src_hazard;
    logic                  other_hazard, late_store, stall_raw, dbg_hold;
    logic [NUM_STAGES-1:0] stage_en, stage_rst;
    ctrl_ev_e              ev;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .NUM_STAGES(NUM_STAGES),
            .ADDR_W    (ADDR_W),
            .LOAD_LAT  (LOAD_LAT),
            .FW        (FW)
        ) u_match (
            .used    (bus.id_src_used[i]),
            .addr    (bus.id_src_addr[i*ADDR_W +: ADDR_W]),
            .sb_valid(sb_valid_q),
            .sb_wen  (sb_wen_q),
            .sb_load (sb_load_q),
            .sb_waddr(sb_waddr_q),
            .sel     (src_sel[i]),
            .hazard  (src_hazard[i])
        );
    end

    // Store data from a load one stage short of ready can be picked up late in MEM.
    always_comb begin
        other_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i != int'(DATA_SRC)) other_hazard = other_hazard | src_hazard[i];
        end
        late_store = (NUM_SRC > 1) && bus.id_is_store && src_hazard[DATA_SRC] && !other_hazard &&
                     (src_sel[DATA_SRC] == FW'(1 + LOAD_LAT));
        stall_raw  = (|src_hazard) && !late_store;
        dbg_hold   = (DBG_EN != 0) && bus.debug_en && !(bus.debug_step && !step_prev_q);
    end

    always_comb begin
        stage_en       = '1;
        stage_rst      = '0;
        bus.fwd_sel    = '0;
        bus.fwd_m      = 1'b0;
        bus.load_stall = 1'b0;
        ev             = EvNone;
        if (rst) begin
            stage_rst = '1;
            ev        = EvReset;
        end else begin
            bus.fwd_m      = late_store;
            bus.load_stall = stall_raw;
            for (int i = 0; i < NUM_SRC; i++) begin
                bus.fwd_sel[i*FW +: FW] = src_hazard[i] ? FW'(FWD_REGFILE) : src_sel[i];
            end
            if (dbg_hold) begin
                stage_en = '0;
                ev       = EvDebug;
            end else if (bus.exc_req) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (k < int'(EXC_DEPTH)) stage_rst[k] = 1'b1;
                end
                ev = EvExc;
            end else if (bus.rom_stall) begin
                stage_en[STG_IF]   = 1'b0;
                stage_en[STG_ID]   = 1'b0;
                stage_rst[STG_EXE] = 1'b1;
                ev                 = EvRom;
            end else if (bus.ram_stall) begin
                stage_en[LAST-1:0] = '0;
                stage_rst[LAST]    = 1'b1;
                ev                 = EvRam;
            end else if (stall_raw) begin
                stage_en[STG_IF]   = 1'b0;
                stage_en[STG_ID]   = 1'b0;
                stage_rst[STG_EXE] = 1'b1;
                ev                 = EvLoad;
            end else if (bus.flush_req) begin
                stage_rst[STG_ID] = 1'b1;
                ev                = EvFlush;
            end
        end
        bus.stage_en  = stage_en;
        bus.stage_rst = stage_rst;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q  <= '0;
            sb_wen_q    <= '0;
            sb_load_q   <= '0;
            sb_waddr_q  <= '0;
            step_prev_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            step_prev_q <= bus.debug_step;
            if (stage_rst[STG_EXE]) begin
                sb_valid_q[2] <= 1'b0;
            end else if (stage_en[STG_EXE]) begin
                sb_valid_q[2]             <= bus.id_valid;
                sb_wen_q[2]               <= bus.id_wen;
                sb_load_q[2]              <= bus.id_is_load;
                sb_waddr_q[ADDR_W-1:0]    <= bus.id_waddr;
            end
            for (int k = 3; k < NUM_STAGES; k++) begin
                if (stage_rst[k]) begin
                    sb_valid_q[k] <= 1'b0;
                end else if (stage_en[k]) begin
                    sb_valid_q[k]                     <= sb_valid_q[k-1];
                    sb_wen_q[k]                       <= sb_wen_q[k-1];
                    sb_load_q[k]                      <= sb_load_q[k-1];
                    sb_waddr_q[(k-2)*ADDR_W +: ADDR_W] <= sb_waddr_q[(k-3)*ADDR_W +: ADDR_W];
                end
            end
            if ((ev == EvLoad) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (((ev == EvExc) || (ev == EvFlush)) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=1, one with LOAD_LAT=2 and
// 2-bit counters for saturation.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NUM_STAGES(5), .ADDR_W(5), .NUM_SRC(2), .CNT_W(16)) ia ();
    pipe_hazard_ctrl_if #(.NUM_STAGES(5), .ADDR_W(5), .NUM_SRC(2), .CNT_W(2))  ib ();

    pipe_hazard_ctrl #(
        .NUM_STAGES(5), .ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1),
        .EXC_DEPTH(3), .DBG_EN(1), .CNT_W(16)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ia.slave)
    );

    pipe_hazard_ctrl #(
        .NUM_STAGES(5), .ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(2),
        .EXC_DEPTH(3), .DBG_EN(1), .CNT_W(2)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic a_id(input logic v, input logic [4:0] s0, input logic u0,
                        input logic [4:0] s1, input logic u1, input logic w,
                        input logic [4:0] wa, input logic ld, input logic st);
        ia.id_valid    = v;
        ia.id_src_addr = {s1, s0};
        ia.id_src_used = {u1, u0};
        ia.id_wen      = w;
        ia.id_waddr    = wa;
        ia.id_is_load  = ld;
        ia.id_is_store = st;
    endtask

    task automatic b_id(input logic v, input logic [4:0] s0, input logic u0,
                        input logic [4:0] s1, input logic u1, input logic w,
                        input logic [4:0] wa, input logic ld, input logic st);
        ib.id_valid    = v;
        ib.id_src_addr = {s1, s0};
        ib.id_src_used = {u1, u0};
        ib.id_wen      = w;
        ib.id_waddr    = wa;
        ib.id_is_load  = ld;
        ib.id_is_store = st;
    endtask

    task automatic a_ctl(input logic dbg, input logic step, input logic rom, input logic ram,
                         input logic fl, input logic exc);
        ia.debug_en   = dbg;
        ia.debug_step = step;
        ia.rom_stall  = rom;
        ia.ram_stall  = ram;
        ia.flush_req  = fl;
        ia.exc_req    = exc;
    endtask

    initial begin
        a_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        a_ctl(0, 0, 0, 0, 0, 0);
        ib.debug_en = 0; ib.debug_step = 0; ib.rom_stall = 0;
        ib.ram_stall = 0; ib.flush_req = 0; ib.exc_req = 0;

        // Reset
        settle();
        chk("rst_stage_rst", ia.stage_rst, 5'h1f);
        chk("rst_stage_en", ia.stage_en, 5'h1f);
        chk("rst_fwd_sel", ia.fwd_sel, 0);
        chk("rst_fwd_m", ia.fwd_m, 0);
        chk("rst_load_stall", ia.load_stall, 0);
        tick(); tick();
        chk("rst_stall_cnt", ia.stall_cnt, 0);
        chk("rst_flush_cnt", ia.flush_cnt, 0);
        rst = 0;

        // Back-to-back ALU forwarding
        a_id(1, 1, 1, 2, 1, 1, 3, 0, 0); settle();
        chk("alu_first_sel", ia.fwd_sel, 0);
        chk("alu_first_en", ia.stage_en, 5'h1f);
        chk("alu_first_rst", ia.stage_rst, 5'h00);
        tick();
        a_id(1, 3, 1, 1, 1, 1, 4, 0, 0); settle();
        chk("alu_b2b_sel0", ia.fwd_sel[2:0], 2);
        chk("alu_b2b_sel1", ia.fwd_sel[5:3], 0);
        chk("alu_b2b_stall", ia.load_stall, 0);
        tick();
        a_id(1, 3, 1, 0, 1, 1, 5, 0, 0); settle();
        chk("alu_gap1_sel0", ia.fwd_sel[2:0], 3);
        chk("alu_r0_sel1", ia.fwd_sel[5:3], 0);
        tick();
        a_id(1, 3, 1, 4, 1, 0, 0, 0, 0); settle();
        chk("alu_gap2_sel0", ia.fwd_sel[2:0], 4);
        chk("alu_gap1_sel1", ia.fwd_sel[5:3], 3);
        tick();

        // Load-use
        a_id(1, 29, 1, 0, 0, 1, 5, 1, 0); settle();
        chk("lw_base_sel", ia.fwd_sel, 0);
        tick();
        a_id(1, 5, 1, 2, 1, 1, 6, 0, 0); settle();
        chk("lu_stall", ia.load_stall, 1);
        chk("lu_en", ia.stage_en, 5'b11100);
        chk("lu_rst", ia.stage_rst, 5'b00100);
        chk("lu_fwd_m", ia.fwd_m, 0);
        chk("lu_cnt_before", ia.stall_cnt, 0);
        tick(); settle();
        chk("lu_resolve_stall", ia.load_stall, 0);
        chk("lu_resolve_sel0", ia.fwd_sel[2:0], 3);
        chk("lu_stall_cnt", ia.stall_cnt, 1);
        chk("lu_resolve_en", ia.stage_en, 5'h1f);
        tick();
        a_id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Load then store of the loaded data, then a base-register hazard
        a_id(1, 29, 1, 0, 0, 1, 7, 1, 0); tick();
        a_id(1, 8, 1, 7, 1, 0, 0, 0, 1); settle();
        chk("ls_fwd_m", ia.fwd_m, 1);
        chk("ls_stall", ia.load_stall, 0);
        chk("ls_en", ia.stage_en, 5'h1f);
        tick();
        a_id(1, 29, 1, 0, 0, 1, 9, 1, 0); tick();
        a_id(1, 9, 1, 0, 1, 0, 0, 0, 1); settle();
        chk("base_stall", ia.load_stall, 1);
        chk("base_fwd_m", ia.fwd_m, 0);
        tick(); settle();
        chk("base_sel0", ia.fwd_sel[2:0], 3);
        chk("base_resolved", ia.load_stall, 0);
        chk("base_stall_cnt", ia.stall_cnt, 2);
        tick();

        // rom_stall masks a load-use hazard
        a_id(1, 29, 1, 0, 0, 1, 10, 1, 0); tick();
        a_id(1, 10, 1, 0, 0, 1, 11, 0, 0);
        ia.rom_stall = 1; settle();
        chk("rom_en", ia.stage_en, 5'b11100);
        chk("rom_rst", ia.stage_rst, 5'b00100);
        tick();
        ia.rom_stall = 0; settle();
        chk("rom_stall_cnt", ia.stall_cnt, 2);
        chk("rom_after_sel0", ia.fwd_sel[2:0], 3);
        chk("rom_after_stall", ia.load_stall, 0);
        tick();

        // Exception wins over ram_stall
        a_id(1, 0, 0, 0, 0, 1, 12, 0, 0);
        a_ctl(0, 0, 0, 1, 0, 1); settle();
        chk("exc_rst", ia.stage_rst, 5'b00111);
        chk("exc_en", ia.stage_en, 5'h1f);
        tick();
        a_ctl(0, 0, 0, 0, 0, 0);
        a_id(0, 12, 1, 11, 1, 0, 0, 0, 0); settle();
        chk("exc_sb2_cleared", ia.fwd_sel[2:0], 0);
        chk("exc_sb3_kept", ia.fwd_sel[5:3], 3);
        chk("exc_flush_cnt", ia.flush_cnt, 1);
        tick();

        // ram_stall alone, flush, masked flush
        a_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        a_ctl(0, 0, 0, 1, 0, 0); settle();
        chk("ram_en", ia.stage_en, 5'b10000);
        chk("ram_rst", ia.stage_rst, 5'b10000);
        tick();
        a_ctl(0, 0, 0, 0, 1, 0); settle();
        chk("flush_rst", ia.stage_rst, 5'b00010);
        chk("flush_en", ia.stage_en, 5'h1f);
        tick();
        a_ctl(0, 0, 1, 0, 1, 0); settle();
        chk("mflush_rst", ia.stage_rst, 5'b00100);
        chk("mflush_en", ia.stage_en, 5'b11100);
        tick();
        a_ctl(0, 0, 0, 0, 0, 0); settle();
        chk("flush_cnt", ia.flush_cnt, 2);

        // Debug hold and single step
        ia.debug_en = 1;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("dbg_hold_en", ia.stage_en, 5'h00);
            tick();
        end
        ia.debug_step = 1; settle();
        chk("dbg_step_en", ia.stage_en, 5'h1f);
        tick(); settle();
        chk("dbg_step_held_en", ia.stage_en, 5'h00);
        tick();
        ia.debug_step = 0; settle();
        chk("dbg_step_low_en", ia.stage_en, 5'h00);
        tick();
        ia.debug_en = 0; settle();
        chk("dbg_release_en", ia.stage_en, 5'h1f);

        // LOAD_LAT=2 instance: two-cycle stall, r0, counter saturation
        b_id(1, 29, 1, 0, 0, 1, 5, 1, 0); tick();
        b_id(1, 5, 1, 0, 0, 1, 6, 0, 0); settle();
        chk("ll2_stall_c1", ib.load_stall, 1);
        chk("ll2_en_c1", ib.stage_en, 5'b11100);
        tick(); settle();
        chk("ll2_stall_c2", ib.load_stall, 1);
        chk("ll2_fwd_m", ib.fwd_m, 0);
        tick(); settle();
        chk("ll2_resolved", ib.load_stall, 0);
        chk("ll2_sel0", ib.fwd_sel[2:0], 4);
        chk("ll2_stall_cnt", ib.stall_cnt, 2);
        tick();
        b_id(1, 29, 1, 0, 0, 1, 0, 1, 0); tick();
        b_id(1, 0, 1, 0, 1, 0, 0, 0, 1); settle();
        chk("r0_stall", ib.load_stall, 0);
        chk("r0_fwd_m", ib.fwd_m, 0);
        chk("r0_sel", ib.fwd_sel, 0);
        tick();
        b_id(1, 29, 1, 0, 0, 1, 8, 1, 0); tick();
        b_id(1, 8, 1, 0, 0, 1, 9, 0, 0); tick(); settle();
        chk("sat_stall_c2", ib.load_stall, 1);
        tick(); settle();
        chk("sat_sel0", ib.fwd_sel[2:0], 4);
        chk("sat_stall_cnt", ib.stall_cnt, 3);
        b_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ib.flush_req = 1;
        for (int c = 0; c < 4; c++) tick();
        ib.flush_req = 0; settle();
        chk("sat_flush_cnt", ib.flush_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
